// File: rtl/rom_arbiter.sv
// Two-requester ROM arbiter: load has priority, fetch is protected from starvation.
// Optional grant statistics are enabled with the ROM_ARBITER_STATS_EN macro.
module rom_arbiter #(
    parameter int ROM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch_req,
    input  logic [7:0] fetch_addr,
    output logic       fetch_ack,
    input  logic       load_req,
    input  logic [7:0] load_addr,
    output logic       load_ack,
    output logic [7:0] rd_data,
    output logic       rom_en,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data_in,
    output logic       busy,
    output logic       owner
`ifdef ROM_ARBITER_STATS_EN
    ,
    output logic [15:0] fetch_grants,
    output logic [15:0] load_grants
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [2:0] LAST_WAIT  = 3'(ROM_LATENCY - 1);

    logic [1:0] state;
    logic [2:0] wait_cnt;
    logic [3:0] starve;
    logic       grant_any;
    logic       grant_fetch;

    // Fetch wins only when alone or once load has been granted STARVE_LIMIT times in a row.
    always_comb begin
        grant_any   = fetch_req | load_req;
        grant_fetch = fetch_req & (~load_req | (starve == STARVE_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            starve   <= '0;
            rom_addr <= '0;
            rd_data  <= '0;
            owner    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state    <= ISSUE;
                        owner    <= ~grant_fetch;
                        rom_addr <= grant_fetch ? fetch_addr : load_addr;
                        if (grant_fetch) begin
                            starve <= '0;
                        end else if (fetch_req && (starve < STARVE_MAX)) begin
                            starve <= starve + 4'd1;
                        end
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        state   <= RESP;
                        rd_data <= rom_data_in;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rom_en    = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign fetch_ack = (state == RESP) & ~owner;
    assign load_ack  = (state == RESP) & owner;

`ifdef ROM_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_grants <= '0;
            load_grants  <= '0;
        end else if ((state == IDLE) && grant_any) begin
            if (grant_fetch) begin
                if (fetch_grants != '1) fetch_grants <= fetch_grants + 16'd1;
            end else begin
                if (load_grants != '1) load_grants <= load_grants + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench: two arbiters (ROM_LATENCY 1 and 3, STARVE_LIMIT 2) share stimulus;
// a grant-schedule model checks every cycle, directed literals pin the model.
module tb_rom_arbiter;

    localparam int L0 = 1;
    localparam int L1 = 3;
    localparam int SL = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fetch_req = 1'b0;
    logic       load_req = 1'b0;
    logic [7:0] fetch_addr = 8'h00;
    logic [7:0] load_addr = 8'h00;

    logic [1:0] fack, lack, ren, bsy, own;
    logic [7:0] rd   [2];
    logic [7:0] ra   [2];
    logic [7:0] rdin [2];
`ifdef ROM_ARBITER_STATS_EN
    logic [15:0] fgr [2];
    logic [15:0] lgr [2];
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rom_arbiter #(.ROM_LATENCY(L0), .STARVE_LIMIT(SL)) u0 (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fack[0]),
        .load_req(load_req), .load_addr(load_addr), .load_ack(lack[0]),
        .rd_data(rd[0]), .rom_en(ren[0]), .rom_addr(ra[0]), .rom_data_in(rdin[0]),
        .busy(bsy[0]), .owner(own[0])
`ifdef ROM_ARBITER_STATS_EN
        , .fetch_grants(fgr[0]), .load_grants(lgr[0])
`endif
    );

    rom_arbiter #(.ROM_LATENCY(L1), .STARVE_LIMIT(SL)) u1 (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fack[1]),
        .load_req(load_req), .load_addr(load_addr), .load_ack(lack[1]),
        .rd_data(rd[1]), .rom_en(ren[1]), .rom_addr(ra[1]), .rom_data_in(rdin[1]),
        .busy(bsy[1]), .owner(own[1])
`ifdef ROM_ARBITER_STATS_EN
        , .fetch_grants(fgr[1]), .load_grants(lgr[1])
`endif
    );

    function automatic logic [7:0] rom(input logic [7:0] a);
        return (a == 8'h10) ? 8'hA5 : (a ^ 8'h3C);
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? L0 : L1;
    endfunction

    // ROM drives valid data only in the cycle exactly ROM_LATENCY after the strobe.
    logic [8:0] pp [2][4];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int k = 3; k > 0; k--) pp[i][k] <= pp[i][k-1];
            pp[i][0] <= {ren[i], ra[i]};
        end
    end
    always_comb begin
        rdin[0] = pp[0][L0-1][8] ? rom(pp[0][L0-1][7:0]) : 8'hEE;
        rdin[1] = pp[1][L1-1][8] ? rom(pp[1][L1-1][7:0]) : 8'hEE;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Model: each transaction is described only by its grant cycle, owner and address.
    int         g   [2] = '{-1, -1};
    logic       go  [2];
    logic [7:0] ga  [2];
    int         st  [2] = '{0, 0};
    logic [7:0] e_rd   [2] = '{8'h00, 8'h00};
    logic [7:0] e_addr [2] = '{8'h00, 8'h00};
    logic       e_own  [2] = '{1'b0, 1'b0};
    int         fgm [2] = '{0, 0};
    int         lgm [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int  lt;
            bit  act, resp, fw;
            lt = lat_of(i);
            if (!rst_n) begin
                g[i] = -1; st[i] = 0; e_rd[i] = 8'h00; e_addr[i] = 8'h00;
                e_own[i] = 1'b0; fgm[i] = 0; lgm[i] = 0;
            end
            act  = rst_n && (g[i] >= 0) && (cyc >= g[i] + 1) && (cyc <= g[i] + lt + 2);
            resp = act && (cyc == g[i] + lt + 2);
            if (resp) e_rd[i] = rom(ga[i]);
            chk($sformatf("u%0d_busy", i),   32'(bsy[i]),  32'(act));
            chk($sformatf("u%0d_rom_en", i), 32'(ren[i]),  32'(act && (cyc == g[i] + 1)));
            chk($sformatf("u%0d_fack", i),   32'(fack[i]), 32'(resp && !go[i]));
            chk($sformatf("u%0d_lack", i),   32'(lack[i]), 32'(resp && go[i]));
            chk($sformatf("u%0d_rd", i),     32'(rd[i]),   32'(e_rd[i]));
            chk($sformatf("u%0d_addr", i),   32'(ra[i]),   32'(e_addr[i]));
            chk($sformatf("u%0d_owner", i),  32'(own[i]),  32'(e_own[i]));
`ifdef ROM_ARBITER_STATS_EN
            chk($sformatf("u%0d_fgrants", i), 32'(fgr[i]), 32'(fgm[i]));
            chk($sformatf("u%0d_lgrants", i), 32'(lgr[i]), 32'(lgm[i]));
`endif
            if (rst_n && !act && (fetch_req || load_req)) begin
                fw = fetch_req && (!load_req || (st[i] == SL));
                g[i]  = cyc;
                go[i] = !fw;
                ga[i] = fw ? fetch_addr : load_addr;
                e_addr[i] = ga[i];
                e_own[i]  = go[i];
                if (fw) begin
                    st[i] = 0;
                    if (fgm[i] < 65535) fgm[i]++;
                end else begin
                    if (fetch_req && (st[i] < SL)) st[i]++;
                    if (lgm[i] < 65535) lgm[i]++;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // kind: 0 fetch ack, 1 load ack, 2 either; k = cycles stepped, -1 on timeout
    task automatic wait_ack(input int inst, input int kind, output int k);
        for (int n = 1; n <= 30; n++) begin
            step(1);
            if ((kind != 1 && fack[inst]) || (kind != 0 && lack[inst])) begin
                k = n;
                return;
            end
        end
        k = -1;
        vectors++;
        miscompares++;
        $display("FAIL ack_timeout: got none want ack on u%0d within 30 cycles", inst);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, got, bc;
        logic [5:0] order;
        order = '0;

        repeat (4) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_addr", 32'(ra[0]), 32'd0);
        chk("rst_rd", 32'(rd[0]), 32'd0);
        chk("rst_owner", 32'(own[0]), 32'd0);

        // single fetch, ROM latency 1
        rst_n = 1'b1; fetch_req = 1'b1; fetch_addr = 8'h10;
        step(1);
        chk("f_rom_en", 32'(ren[0]), 32'd1);
        chk("f_rom_addr", 32'(ra[0]), 32'h10);
        chk("f_ack_early", 32'(fack[0]), 32'd0);
        step(2);
        chk("f_ack", 32'(fack[0]), 32'd1);
        chk("f_rd", 32'(rd[0]), 32'hA5);
        step(1); fetch_req = 1'b0;
        step(4);

        // both requesting continuously: starvation guard interleaves fetch
        fetch_addr = 8'h11; load_addr = 8'h40; fetch_req = 1'b1; load_req = 1'b1;
        for (int n = 0; n < 6; n++) begin
            wait_ack(0, 2, k);
            order[n] = lack[0];
        end
        step(1); fetch_req = 1'b0; load_req = 1'b0;
        chk("grant_order", 32'(order), 32'(6'b011011));
        step(8);

        // latency 3 instance: ack 5 cycles after request, busy for 5 cycles
        load_addr = 8'h20; load_req = 1'b1;
        got = -1; bc = 0;
        for (int n = 0; n < 12; n++) begin
            if (bsy[1]) bc++;
            if (got >= 0 && n == got + 1) load_req = 1'b0;
            if (got < 0 && lack[1]) got = n;
            step(1);
        end
        chk("l3_latency", 32'(got), 32'd5);
        chk("l3_busy_cycles", 32'(bc), 32'd5);

        // reset during WAIT aborts the transaction
        fetch_addr = 8'h55; fetch_req = 1'b1;
        step(2);
        chk("rstw_pre_addr", 32'(ra[0]), 32'h55);
        rst_n = 1'b0;
        #1;
        chk("rstw_busy", 32'(bsy[0]), 32'd0);
        chk("rstw_rom_en", 32'(ren[0]), 32'd0);
        chk("rstw_acks", 32'({fack[0], lack[0]}), 32'd0);
        chk("rstw_rd", 32'(rd[0]), 32'd0);
        chk("rstw_addr", 32'(ra[0]), 32'd0);
        chk("rstw_owner", 32'(own[0]), 32'd0);
        step(2);
        rst_n = 1'b1;
        wait_ack(0, 0, k);
        chk("rstw_latency", 32'(k), 32'd3);
        step(1); fetch_req = 1'b0;
        step(6);

        // address change after grant must not disturb the transaction
        load_addr = 8'h30; load_req = 1'b1;
        step(1);
        load_addr = 8'h31;
        wait_ack(0, 1, k);
        chk("addr_hold_lat", 32'(k), 32'd2);
        chk("addr_hold_rom", 32'(ra[0]), 32'h30);
        chk("addr_hold_rd", 32'(rd[0]), 32'h0C);
        step(1); load_req = 1'b0;
        step(8);

`ifdef ROM_ARBITER_STATS_EN
        chk("stats_u0_fetch", 32'(fgr[0]), 32'd1);
        chk("stats_u0_load", 32'(lgr[0]), 32'd1);
        chk("stats_u1_fetch", 32'(fgr[1]), 32'd1);
        chk("stats_u1_load", 32'(lgr[1]), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
